// File: rtl/pcieifc_fifo_downsizer.sv
// Pops wide entries from a first-word-fall-through FIFO and replays each one
// as 1..RATIO narrow AXI-Stream beats, least significant segment first.
module pcieifc_fifo_downsizer #(
  parameter int IN_WIDTH  = 192,
  parameter int OUT_WIDTH = 64
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      fifo_empty,
  output logic                                      fifo_ren,
  input  logic [IN_WIDTH+((IN_WIDTH/OUT_WIDTH) > 1 ? $clog2(IN_WIDTH/OUT_WIDTH) : 1):0] fifo_dout,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic [OUT_WIDTH-1:0]                      m_axis_tdata,
  output logic                                      m_axis_tlast,
  output logic                                      err_seg_cnt,
  output logic [31:0]                               pkt_cnt
);

  localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
  localparam int CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int FIFO_W = IN_WIDTH + CNT_W + 1;
  localparam logic [CNT_W-1:0] MAX_SEG = CNT_W'(RATIO - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e                state_q, state_d;
  logic [IN_WIDTH-1:0]   hold_data_q, hold_data_d;
  logic                  hold_last_q, hold_last_d;
  logic [CNT_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]      idx_q, idx_d;
  logic                  err_q, err_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;

  logic                  in_last;
  logic [CNT_W-1:0]      in_cnt;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  seg_bad;
  logic                  beat_acc;
  logic                  at_final;

  assign in_last = fifo_dout[FIFO_W-1];
  assign in_cnt  = fifo_dout[IN_WIDTH +: CNT_W];
  assign in_data = fifo_dout[IN_WIDTH-1:0];
  assign seg_bad = (in_cnt > MAX_SEG);

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tdata  = hold_data_q[idx_q*OUT_WIDTH +: OUT_WIDTH];
  assign at_final      = (idx_q == hold_cnt_q);
  assign m_axis_tlast  = m_axis_tvalid && hold_last_q && at_final;
  assign beat_acc      = m_axis_tvalid && m_axis_tready;

  // Popping on the final accepted beat refills the holding register in the
  // same cycle, so back-to-back entries stream without a bubble.
  assign fifo_ren = !rst && !fifo_empty && ((state_q == IDLE) || (beat_acc && at_final));

  assign err_seg_cnt = err_q;
  assign pkt_cnt     = pkt_cnt_q;

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    hold_cnt_d  = hold_cnt_q;
    idx_d       = idx_q;
    err_d       = err_q;
    pkt_cnt_d   = pkt_cnt_q;

    if (fifo_ren) begin
      state_d     = SEND;
      hold_data_d = in_data;
      hold_last_d = in_last;
      hold_cnt_d  = seg_bad ? MAX_SEG : in_cnt;
      idx_d       = '0;
      err_d       = err_q | seg_bad;
    end else if (beat_acc) begin
      if (at_final) begin
        state_d = IDLE;
      end else begin
        idx_d = idx_q + CNT_W'(1);
      end
    end

    if (beat_acc && m_axis_tlast) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      hold_cnt_q  <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      hold_cnt_q  <= hold_cnt_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

endmodule

// File: tb/tb_pcieifc_fifo_downsizer.sv
// Bench for pcieifc_fifo_downsizer: a queue-based FIFO model feeds the DUT and
// a beat scoreboard derived from each pushed entry checks every accepted beat.
module tb_pcieifc_fifo_downsizer;

  localparam int IN_WIDTH  = 192;
  localparam int OUT_WIDTH = 64;
  localparam int FIFO_W    = 195;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 fifo_empty;
  logic                 fifo_ren;
  logic [FIFO_W-1:0]    fifo_dout;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [OUT_WIDTH-1:0] m_axis_tdata;
  logic                 m_axis_tlast;
  logic                 err_seg_cnt;
  logic [31:0]          pkt_cnt;

  logic [FIFO_W-1:0]    fifoQ[$];
  beat_t                expBeats[$];
  logic [31:0]          pktModel;
  logic                 errModel;
  int                   beatsSeen;
  int                   checks;
  int                   failures;

  always #5 clk = ~clk;

  pcieifc_fifo_downsizer #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_ren     (fifo_ren),
    .fifo_dout    (fifo_dout),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tlast (m_axis_tlast),
    .err_seg_cnt  (err_seg_cnt),
    .pkt_cnt      (pkt_cnt)
  );

  task automatic checkOutput(input string tag, input logic [FIFO_W-1:0] obs,
                             input logic [FIFO_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue an entry in the FIFO model and append the beats it must produce.
  task automatic pushEntry(input logic [IN_WIDTH-1:0] data, input logic [1:0] cnt,
                           input logic last);
    int segs;
    beat_t b;
    segs = (cnt > 2'd2) ? 3 : int'(cnt) + 1;
    fifoQ.push_back({last, cnt, data});
    for (int i = 0; i < segs; i++) begin
      b.data = data[i*OUT_WIDTH +: OUT_WIDTH];
      b.last = last && (i == segs - 1);
      expBeats.push_back(b);
    end
    fifo_empty = 1'b0;
    fifo_dout  = fifoQ[0];
  endtask

  // One clock: sample just after the negedge, score the beat and pop, then
  // advance to the next negedge and refresh the FIFO model outputs.
  task automatic applyStimulus();
    logic sRen, sValid, sLast, sRst, sReady;
    logic [63:0] sData;
    logic [FIFO_W-1:0] e;
    beat_t b;
    #1;
    sRen = fifo_ren; sValid = m_axis_tvalid; sLast = m_axis_tlast;
    sData = m_axis_tdata; sRst = rst; sReady = m_axis_tready;
    if (sValid && sReady) begin
      beatsSeen++;
      if (expBeats.size() == 0) begin
        checkOutput("unexpected_beat", 1, 0);
      end else begin
        b = expBeats.pop_front();
        checkOutput("beat_data", sData, b.data);
        checkOutput("beat_last", sLast, b.last);
        if (b.last) pktModel = pktModel + 32'd1;
      end
    end
    if (sRen) begin
      if (fifoQ.size() == 0) begin
        checkOutput("pop_on_empty", 1, 0);
      end else begin
        e = fifoQ.pop_front();
        if (e[IN_WIDTH +: 2] == 2'd3) errModel = 1'b1;
      end
    end
    if (sRst) begin
      pktModel = '0;
      errModel = 1'b0;
      expBeats.delete();
    end
    @(posedge clk);
    @(negedge clk);
    fifo_empty = (fifoQ.size() == 0);
    fifo_dout  = fifo_empty ? '0 : fifoQ[0];
    checkOutput("pkt_cnt", pkt_cnt, pktModel);
    checkOutput("err_seg_cnt", err_seg_cnt, errModel);
  endtask

  task automatic drain(input int maxCycles);
    int n;
    n = 0;
    m_axis_tready = 1'b1;
    while ((expBeats.size() > 0 || fifoQ.size() > 0) && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    checkOutput("drain_complete", expBeats.size(), 0);
  endtask

  initial begin
    logic [IN_WIDTH-1:0] d;
    int b0;
    bit expRen[6];
    bit expValid[6];

    checks = 0; failures = 0; beatsSeen = 0;
    pktModel = '0; errModel = 1'b0;
    rst = 1'b1; fifo_empty = 1'b1; fifo_dout = '0; m_axis_tready = 1'b0;

    @(negedge clk);
    applyStimulus();
    fifo_empty = 1'b0;
    fifo_dout  = {1'b1, 2'd2, 192'h1234};
    #1 checkOutput("ren_during_reset", fifo_ren, 0);
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    applyStimulus();
    rst = 1'b0;
    #1;
    checkOutput("reset_tvalid", m_axis_tvalid, 0);
    checkOutput("reset_tlast", m_axis_tlast, 0);
    checkOutput("reset_tdata", m_axis_tdata, 0);
    checkOutput("reset_ren", fifo_ren, 0);
    applyStimulus();

    $display("[TB] single three-segment entry");
    m_axis_tready = 1'b1;
    pushEntry({64'hCCCC_CCCC_CCCC_CCCC, 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
              2'd2, 1'b1);
    #1;
    checkOutput("t1_ren_same_cycle", fifo_ren, 1);
    checkOutput("t1_valid_at_load", m_axis_tvalid, 0);
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      #1 checkOutput("t1_valid_beat", m_axis_tvalid, 1);
      applyStimulus();
    end
    #1;
    checkOutput("t1_valid_after", m_axis_tvalid, 0);
    checkOutput("t1_pkt", pkt_cnt, 1);
    applyStimulus();

    $display("[TB] two queued entries, no bubble");
    pushEntry({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'd2, 1'b0);
    pushEntry({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'd0, 1'b1);
    expRen   = '{1, 0, 0, 1, 0, 0};
    expValid = '{0, 1, 1, 1, 1, 0};
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput("t2_ren", fifo_ren, expRen[i]);
      checkOutput("t2_valid", m_axis_tvalid, expValid[i]);
      applyStimulus();
    end

    $display("[TB] backpressure on second beat");
    d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    pushEntry(d, 2'd2, 1'b1);
    applyStimulus();
    applyStimulus();
    pushEntry({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'd0, 1'b1);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("t3_valid_held", m_axis_tvalid, 1);
      checkOutput("t3_data_held", m_axis_tdata, d[127:64]);
      checkOutput("t3_last_held", m_axis_tlast, 0);
      checkOutput("t3_no_ren", fifo_ren, 0);
      applyStimulus();
    end
    drain(20);
    applyStimulus();

    $display("[TB] illegal segment count");
    b0 = beatsSeen;
    pushEntry({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'd3, 1'b1);
    applyStimulus();
    #1 checkOutput("t4_err_after_load", err_seg_cnt, 1);
    drain(20);
    applyStimulus();
    applyStimulus();
    checkOutput("t4_beat_count", beatsSeen - b0, 3);
    checkOutput("t4_err_sticky", err_seg_cnt, 1);

    $display("[TB] reset mid-entry");
    pushEntry({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'd2, 1'b1);
    applyStimulus();
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    #1;
    checkOutput("t5_valid_after_reset", m_axis_tvalid, 0);
    checkOutput("t5_tdata_after_reset", m_axis_tdata, 0);
    pushEntry({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'd2, 1'b1);
    drain(20);
    applyStimulus();

    $display("[TB] packet counter wrap");
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    pktModel = 32'hFFFF_FFFF;
    applyStimulus();
    release dut.pkt_cnt_q;
    applyStimulus();
    pushEntry({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2'd0, 1'b1);
    drain(20);
    checkOutput("t6_pkt_wrapped", pkt_cnt, 0);
    applyStimulus();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      if (fifoQ.size() < 4 && $urandom_range(0, 2) != 0) begin
        pushEntry({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      m_axis_tready = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    drain(200);
    applyStimulus();
    #1 checkOutput("final_idle", m_axis_tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcieifc_fifo_downsizer.md
Name: pcieifc_fifo_downsizer

Overview:
- Sits directly downstream of the PCIe interface async FIFO, in the read clock domain.
- Pops wide FIFO entries and serialises each into 1..RATIO narrow AXI-Stream beats, LSB segment first.
- Honours per-entry valid-segment count and packet-end flag.
- Provides back-to-back entry consumption with no bubble, plus simple debug status.

Parameters:
- IN_WIDTH, 192, payload width of one FIFO entry; must be an integer multiple of OUT_WIDTH.
- OUT_WIDTH, 64, output beat width.
- RATIO (localparam), IN_WIDTH/OUT_WIDTH = 3, maximum segments per entry.
- CNT_W (localparam), max(1, clog2(RATIO)) = 2, width of the segment-count field.
- FIFO_W (localparam), IN_WIDTH+CNT_W+1 = 195, FIFO entry width.

Ports:
- clk  in  1  single clock (FIFO read clock).
- rst  in  1  synchronous reset, active-high.
- fifo_empty  in  1  FIFO has no entry; fifo_dout is valid whenever 0 (first-word-fall-through).
- fifo_ren  out  1  pop strobe; the entry is consumed in the same cycle.
- fifo_dout  in  FIFO_W  entry fields: [FIFO_W-1] last, [IN_WIDTH+CNT_W-1:IN_WIDTH] seg_cnt (valid segments minus 1), [IN_WIDTH-1:0] data.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  OUT_WIDTH  current segment.
- m_axis_tlast  out  1  final beat of packet.
- err_seg_cnt  out  1  sticky flag: seg_cnt > RATIO-1 was seen.
- pkt_cnt  out  32  count of accepted tlast beats; wraps at 2^32.

Behaviour:
- Registers:
  - hold_data[IN_WIDTH], hold_last, hold_cnt[CNT_W], idx[CNT_W].
  - FSM with states IDLE (holding register empty) and SEND (holding register valid).
- Reset (rst=1 at a clock edge):
  - FSM enters IDLE; idx=0; err_seg_cnt=0; pkt_cnt=0.
  - Outputs during and after reset until the next load: m_axis_tvalid=0, m_axis_tlast=0, fifo_ren=0, m_axis_tdata=0 (hold_data cleared).
  - Reset mid-packet drops the held entry. Nothing is popped in the reset cycle.
- Beat output (combinational from registers):
  - m_axis_tvalid = (state==SEND).
  - m_axis_tdata = hold_data[idx*OUT_WIDTH +: OUT_WIDTH].
  - m_axis_tlast = SEND && hold_last && idx==hold_cnt.
- Beat accept = tvalid && tready. final_acc = accept && idx==hold_cnt.
- fifo_ren = !rst && !fifo_empty && (state==IDLE || final_acc). It never depends on fifo_dout contents.
- Load (fifo_ren=1):
  - hold_data <= data, hold_last <= last, idx <= 0, state <= SEND.
  - hold_cnt <= seg_cnt clamped to RATIO-1. If seg_cnt > RATIO-1 (e.g. 3 when RATIO=3), set err_seg_cnt (sticky until reset) and clamp.
- Transitions:
  - IDLE and !fifo_empty: load, go to SEND.
  - IDLE and empty: stay in IDLE.
  - SEND, accept, not final: idx++.
  - SEND and final_acc: load if !fifo_empty (stay in SEND, no bubble); otherwise go to IDLE.
  - SEND and !tready: hold all state; tdata and tlast stay stable (AXIS rule).
- Latency: entry visible (fifo_empty falls) at cycle t, state IDLE → fifo_ren=1 at t, first beat valid at t+1.
- Throughput: 1 beat/cycle sustained, including across entry boundaries.
- pkt_cnt increments on each accepted beat with m_axis_tlast=1; wraps from 0xFFFFFFFF to 0.
- Entries with last=0 produce no tlast. Packets may span any number of entries.

Test Plan:
- One entry, data=0xCCCC..._BBBB..._AAAA... (three 64-bit lanes), seg_cnt=2, last=1, tready=1, empty falls at cycle 5 → fifo_ren=1 at 5; beats at 6,7,8 = 0xAAAA...,0xBBBB...,0xCCCC...; tlast only at 8; pkt_cnt=1; tvalid=0 at 9.
- Two entries queued (seg_cnt=2/last=0, seg_cnt=0/last=1), tready=1 → second fifo_ren coincides with the third beat; 4 contiguous beats, no gap; tlast on beat 4 only.
- Backpressure: tready low at 2nd beat for 3 cycles → tdata/tlast held stable; idx frozen; no fifo_ren; sequence resumes unchanged.
- Illegal seg_cnt=3, last=1 → err_seg_cnt=1 the cycle after the load; exactly 3 beats emitted; flag persists after the packet.
- rst=1 while idx=1 of a 3-segment entry → next cycle tvalid=0, pkt_cnt=0, err_seg_cnt=0; the next FIFO entry is emitted from segment 0.
- Force pkt_cnt to 0xFFFFFFFF, send one last=1 entry → pkt_cnt=0 after the tlast accept.
